// File: rtl/naive_bus_sram_slave_if.sv
// Core request/grant bus: independent read and write channels with combinational grants.
// Read data follows its grant by one cycle.
interface naive_bus;
  logic        rd_req;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_gnt;

  modport slave (
    input  rd_req, rd_be, rd_addr,
    output rd_gnt, rd_data,
    input  wr_req, wr_be, wr_addr, wr_data,
    output wr_gnt
  );

  modport master (
    output rd_req, rd_be, rd_addr,
    input  rd_gnt, rd_data,
    output wr_req, wr_be, wr_addr, wr_data,
    input  wr_gnt
  );
endinterface

// File: rtl/naive_bus_sram_slave.sv
// Single-port word SRAM behind the naive bus; reads win over writes, optional read wait states.
// Grants are combinational; read data is registered and appears the cycle after the grant.
module naive_bus_sram_slave #(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input logic       clk,
  input logic       rst_n,
  naive_bus.slave   bus_slave
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  rd_req;
  logic [3:0]            rd_be;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_gnt;
  logic [31:0]           rd_data;
  logic                  wr_req;
  logic [3:0]            wr_be;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [31:0]           wr_data;
  logic                  wr_gnt;
  logic [31:0]           rd_mask;
  logic                  unused_addr_bits;

  logic [31:0] mem [DEPTH];

  assign rd_req  = bus_slave.rd_req;
  assign rd_be   = bus_slave.rd_be;
  assign rd_idx  = bus_slave.rd_addr[DEPTH_LOG2+1:2];
  assign wr_req  = bus_slave.wr_req;
  assign wr_be   = bus_slave.wr_be;
  assign wr_idx  = bus_slave.wr_addr[DEPTH_LOG2+1:2];
  assign wr_data = bus_slave.wr_data;

  // Address bits outside the word index are don't-care; the array wraps.
  assign unused_addr_bits = ^{bus_slave.rd_addr[31:DEPTH_LOG2+2], bus_slave.rd_addr[1:0],
                              bus_slave.wr_addr[31:DEPTH_LOG2+2], bus_slave.wr_addr[1:0]};

  // A pending read, even one still in its wait states, blocks the write port.
  assign wr_gnt = wr_req & ~rd_req;

  assign rd_mask = {{8{rd_be[3]}}, {8{rd_be[2]}}, {8{rd_be[1]}}, {8{rd_be[0]}}};

  generate
    if (WAIT_CYCLES == 0) begin : g_nowait
      assign rd_gnt = rd_req;
    end else begin : g_wait
      typedef enum logic {S_IDLE, S_WAIT} state_t;
      localparam logic [2:0] RELOAD = 3'(WAIT_CYCLES - 1);

      state_t                state;
      logic [2:0]            cnt;
      logic [DEPTH_LOG2-1:0] lat_addr;

      assign rd_gnt = (state == S_WAIT) && rd_req && (rd_idx == lat_addr) && (cnt == 3'd0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state    <= S_IDLE;
          cnt      <= 3'd0;
          lat_addr <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              if (rd_req) begin
                state    <= S_WAIT;
                cnt      <= RELOAD;
                lat_addr <= rd_idx;
              end
            end
            S_WAIT: begin
              if (!rd_req) begin
                state <= S_IDLE;
              end else if (rd_idx != lat_addr) begin
                // Master moved to another word: the wait starts over for it.
                cnt      <= RELOAD;
                lat_addr <= rd_idx;
              end else if (cnt == 3'd0) begin
                state <= S_IDLE;
              end else begin
                cnt <= cnt - 3'd1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_gnt && wr_be[b]) begin
        mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 32'h0;
    end else if (rd_gnt) begin
      rd_data <= mem[rd_idx] & rd_mask;
    end
  end

  assign bus_slave.rd_gnt  = rd_gnt;
  assign bus_slave.rd_data = rd_data;
  assign bus_slave.wr_gnt  = wr_gnt;

endmodule

// File: doc/naive_bus_sram_slave.md
NAIVE_BUS_SRAM_SLAVE -- requirements
Module: naive_bus_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of the number of 32-bit words (legal range 4..16).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, meaning read wait states inserted before grant (legal range 0..7).
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port bus_slave  naive_bus.slave  --  responder end of the core bus, with the members in REQ-006..REQ-015.
REQ-006 SHALL have member rd_req  input  1  read request, held by the master until granted.
REQ-007 SHALL have member rd_be  input  4  read byte enables.
REQ-008 SHALL have member rd_addr  input  32  byte read address; word index is rd_addr[DEPTH_LOG2+1:2].
REQ-009 SHALL have member rd_gnt  output  1  read grant, combinational, in the same cycle as the request.
REQ-010 SHALL have member rd_data  output  32  read data, valid the cycle after grant.
REQ-011 SHALL have member wr_req  input  1  write request.
REQ-012 SHALL have member wr_be  input  4  write byte enables.
REQ-013 SHALL have member wr_addr  input  32  byte write address; word index is wr_addr[DEPTH_LOG2+1:2].
REQ-014 SHALL have member wr_data  input  32  write data.
REQ-015 SHALL have member wr_gnt  output  1  write grant, combinational.

Function
REQ-016 SHALL hold 2^DEPTH_LOG2 words of single-port storage; one access (read or write) per cycle.
REQ-017 SHALL ignore address bits above DEPTH_LOG2+1 and bits [1:0]; the address wraps modulo the depth.
REQ-018 SHALL, with WAIT_CYCLES=0, assert rd_gnt whenever rd_req=1.
REQ-019 SHALL, with WAIT_CYCLES=N>0, implement states IDLE and WAIT with a 3-bit down-counter cnt.
REQ-020 SHALL, in IDLE with rd_req=1: drive rd_gnt=0, load cnt=N-1, capture rd_addr word index into lat_addr, and go to WAIT.
REQ-021 SHALL, in WAIT with rd_req=1 and a word index equal to lat_addr: drive rd_gnt=(cnt==0), and decrement cnt while cnt>0.
REQ-022 SHALL, in WAIT when cnt==0 and the read is granted: go to IDLE, so the next read again incurs N wait cycles.
REQ-023 SHALL, in WAIT when rd_req=0: drive rd_gnt=0 and go to IDLE (request abandoned).
REQ-024 SHALL, in WAIT when rd_req=1 and the word index differs from lat_addr (master redirected): drive rd_gnt=0, reload cnt=N-1, and capture the new index.
REQ-025 SHALL, on a granted read, register mem[index] with bytes whose rd_be bit is 0 forced to 8'h00, and present it on rd_data in the next cycle.
REQ-026 SHALL hold rd_data at its last value in every cycle that follows a cycle without a read grant.
REQ-027 SHALL give reads priority: wr_gnt = wr_req & ~rd_req. This covers any cycle with rd_req=1, including wait cycles.
REQ-028 SHALL, on a granted write, update only the bytes of mem[index] whose wr_be bit is 1; a write with wr_be=0 is granted and changes nothing.
REQ-029 SHALL return the previously stored data when a read follows a write to the same word in the next cycle (no bypass needed, writes complete at the edge).
REQ-030 SHALL require no handshake beyond request/grant; a master retrying with the same address after rd_gnt=0 is the normal flow.

Reset
REQ-031 SHALL, on rst_n=0 (asynchronous), force state=IDLE, cnt=0, lat_addr=0, rd_data=32'h0.
REQ-032 SHALL keep rd_gnt and wr_gnt combinational, so both read 0 during reset whenever the requests are 0.
REQ-033 SHALL not initialise or clear memory contents on reset.
REQ-034 SHALL, if reset asserts during WAIT, abandon the pending read; after release the read restarts the full N-cycle wait.

Verification
REQ-035 SHALL check (WAIT_CYCLES=0): write 0xDEADBEEF to addr 0x10 with be=4'hF, then read 0x10 -> rd_gnt=1 in the same cycle, rd_data=0xDEADBEEF in the next cycle.
REQ-036 SHALL check: write 0x000000AA to addr 0x10 with be=4'b0001, then read with be=4'b0011 -> rd_data=0x0000BEAA.
REQ-037 SHALL check (WAIT_CYCLES=3): rd_req held on addr 0x20 -> rd_gnt=0 for 3 cycles, rd_gnt=1 on the 4th, data on the 5th; back-to-back reads each take 4 cycles.
REQ-038 SHALL check (WAIT_CYCLES=3): address changes to 0x24 after 2 wait cycles -> the count restarts and rd_gnt=1 on the 4th cycle counted from the change; data = mem[0x24].
REQ-039 SHALL check: simultaneous rd_req and wr_req -> wr_gnt=0 and memory unchanged; wr_gnt=1 in the first cycle with rd_req=0.
REQ-040 SHALL check: rst_n pulsed low mid-WAIT -> rd_data=0 immediately and state IDLE; the next read takes the full WAIT_CYCLES+1 cycles.
